// File: rtl/alu_rs_scheduler_pkg.sv
// Shared types for the ALU reservation station: instruction payload, slot entry and wakeup helpers.
// Pure declarations; no state, no timing of its own.
// Backpressure is not applicable here; flow control lives in alu_rs_scheduler.
package core_types_pkg;

    localparam int ALU_RS_DEPTH = 4;

    typedef logic [5:0] phys_reg_tag_t;
    typedef logic [4:0] ROB_index_t;

    typedef struct packed {
        logic          needed;
        logic          ready;
        phys_reg_tag_t phys_reg_tag;
    } ALU_RS_src_t;

    typedef struct packed {
        logic [3:0]    op;
        logic [1:0]    itype;
        ALU_RS_src_t   source_0;
        ALU_RS_src_t   source_1;
        phys_reg_tag_t dest_tag;
        logic [15:0]   imm16;
        ROB_index_t    ROB_index;
    } ALU_RS_input_struct_t;

    typedef struct packed {
        logic                 valid;
        ALU_RS_input_struct_t instr;
    } ALU_RS_entry_t;

    function automatic ALU_RS_src_t alu_rs_wake_src(input ALU_RS_src_t src,
                                                    input logic [1:0] wb_valid,
                                                    input phys_reg_tag_t [1:0] wb_tag);
        ALU_RS_src_t res;
        res = src;
        for (int b = 0; b < 2; b++) begin
            if (src.needed && !src.ready && wb_valid[b] && (wb_tag[b] == src.phys_reg_tag)) begin
                res.ready = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic ALU_RS_input_struct_t alu_rs_wake_instr(input ALU_RS_input_struct_t ins,
                                                              input logic [1:0] wb_valid,
                                                              input phys_reg_tag_t [1:0] wb_tag);
        ALU_RS_input_struct_t res;
        res          = ins;
        res.source_0 = alu_rs_wake_src(ins.source_0, wb_valid, wb_tag);
        res.source_1 = alu_rs_wake_src(ins.source_1, wb_valid, wb_tag);
        return res;
    endfunction

    function automatic logic alu_rs_src_sat(input ALU_RS_src_t src);
        return !src.needed || src.ready;
    endfunction

endpackage

// File: rtl/alu_rs_scheduler_if.sv
// Dispatch / wakeup / issue / kill bundle between the rename stage, the scheduler and the ALU.
// Wires only; timing is defined by the modules on either side.
// Dispatch and issue use valid/ready handshakes; wakeup and kill are unconditional broadcasts.
interface alu_rs_scheduler_if;
    import core_types_pkg::*;

    logic                 dispatch_valid;
    logic                 dispatch_ready;
    ALU_RS_input_struct_t dispatch_struct;
    logic [1:0]           wb_valid;
    phys_reg_tag_t [1:0]  wb_tag;
    logic                 issue_valid;
    logic                 issue_ready;
    ALU_RS_input_struct_t issue_struct;
    logic                 kill_valid;
    ROB_index_t           kill_ROB_index;
    ROB_index_t           ROB_head_index;

    modport master (
        output dispatch_valid, dispatch_struct, wb_valid, wb_tag, issue_ready,
               kill_valid, kill_ROB_index, ROB_head_index,
        input  dispatch_ready, issue_valid, issue_struct
    );

    modport slave (
        input  dispatch_valid, dispatch_struct, wb_valid, wb_tag, issue_ready,
               kill_valid, kill_ROB_index, ROB_head_index,
        output dispatch_ready, issue_valid, issue_struct
    );

endinterface

// File: rtl/alu_rs_scheduler_select.sv
// Oldest-first picker: lowest set bit of the eligible vector, as one-hot and binary index.
// Purely combinational, zero latency.
// No backpressure; any_o tells the caller whether the outputs mean anything.
module alu_rs_select #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = |eligible_i;
        // Scan from the young end so the oldest eligible slot wins last.
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs_scheduler.sv
// Compacting ALU reservation station; slot 0 is oldest. ALU_RS_BYPASS_WAKEUP_EN lets same-cycle wakeups issue.
// Dispatch lands one edge after acceptance; wakeup-to-issue is one cycle (zero with the bypass).
// dispatch_ready drops when full, killing or in reset; issue holds until issue_ready, selection may change meanwhile.
module alu_rs_scheduler
    import core_types_pkg::*;
#(
    parameter int ALU_RS_DEPTH = core_types_pkg::ALU_RS_DEPTH
) (
    input logic              CLK,
    input logic              RST,
    alu_rs_scheduler_if.slave bus
);

    localparam int IW = (ALU_RS_DEPTH > 1) ? $clog2(ALU_RS_DEPTH) : 1;
    localparam int CW = $clog2(ALU_RS_DEPTH + 1);

    ALU_RS_entry_t           entries_q [ALU_RS_DEPTH];
    ALU_RS_entry_t           entries_d [ALU_RS_DEPTH];
    logic [CW-1:0]           count_q, count_d;
    ALU_RS_input_struct_t    woken [ALU_RS_DEPTH];
    ALU_RS_input_struct_t    disp_woken;
    ROB_index_t              age [ALU_RS_DEPTH];
    ROB_index_t              kill_age;
    logic [ALU_RS_DEPTH-1:0] survive, eligible, sel_onehot;
    logic [IW-1:0]           sel_idx;
    logic                    sel_any, fire;
    logic [CW-1:0]           pos;

    assign disp_woken = alu_rs_wake_instr(bus.dispatch_struct, bus.wb_valid, bus.wb_tag);

    always_comb begin
        kill_age = bus.kill_ROB_index - bus.ROB_head_index;
        for (int i = 0; i < ALU_RS_DEPTH; i++) begin
            woken[i]   = alu_rs_wake_instr(entries_q[i].instr, bus.wb_valid, bus.wb_tag);
            // Age relative to the ROB head makes the 5-bit wrap of ROB indices harmless.
            age[i]     = entries_q[i].instr.ROB_index - bus.ROB_head_index;
            survive[i] = entries_q[i].valid && !(bus.kill_valid && (age[i] > kill_age));
`ifdef ALU_RS_BYPASS_WAKEUP_EN
            eligible[i] = survive[i] && alu_rs_src_sat(woken[i].source_0)
                                     && alu_rs_src_sat(woken[i].source_1);
`else
            eligible[i] = survive[i] && alu_rs_src_sat(entries_q[i].instr.source_0)
                                     && alu_rs_src_sat(entries_q[i].instr.source_1);
`endif
        end
    end

    alu_rs_select #(.N(ALU_RS_DEPTH)) u_select (
        .eligible_i (eligible),
        .onehot_o   (sel_onehot),
        .idx_o      (sel_idx),
        .any_o      (sel_any)
    );

    assign bus.issue_valid    = sel_any && !RST;
    assign bus.issue_struct   = woken[sel_idx];
    assign bus.dispatch_ready = (count_q < CW'(ALU_RS_DEPTH)) && !bus.kill_valid && !RST;
    assign fire               = bus.issue_valid && bus.issue_ready;

    // Survivors that did not fire slide down in age order; a new dispatch lands right behind them.
    always_comb begin
        pos = '0;
        for (int i = 0; i < ALU_RS_DEPTH; i++) begin
            entries_d[i] = '0;
        end
        for (int i = 0; i < ALU_RS_DEPTH; i++) begin
            if (survive[i] && !(fire && sel_onehot[i])) begin
                entries_d[pos[IW-1:0]].valid = 1'b1;
                entries_d[pos[IW-1:0]].instr = woken[i];
                pos = pos + CW'(1);
            end
        end
        if (bus.dispatch_valid && bus.dispatch_ready) begin
            entries_d[pos[IW-1:0]].valid = 1'b1;
            entries_d[pos[IW-1:0]].instr = disp_woken;
            pos = pos + CW'(1);
        end
        count_d = pos;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
            for (int i = 0; i < ALU_RS_DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: hand sequences for multi-cycle corners plus a kill-age table.
module tb_alu_rs_scheduler;
    import core_types_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    alu_rs_scheduler_if intf();

    alu_rs_scheduler #(.ALU_RS_DEPTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (intf.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    ROB_index_t sb[$];

    typedef struct {
        int head;
        int rob[4];
        int kill;
        int exp_cnt;
    } kill_vec_t;
    kill_vec_t kv[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Checks dispatch acceptance and scoreboards any fire, then steps to just after the next edge.
    task automatic adv();
        ROB_index_t exp_rob;
        @(negedge CLK);
        if (intf.dispatch_valid) chk("dispatch_accept", int'(intf.dispatch_ready), 1);
        if (intf.issue_valid && intf.issue_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue_rob", int'(intf.issue_struct.ROB_index), -1);
            end else begin
                exp_rob = sb.pop_front();
                chk("issue_rob", int'(intf.issue_struct.ROB_index), int'(exp_rob));
            end
        end
        @(posedge CLK);
        #1;
        intf.dispatch_valid = 1'b0;
        intf.wb_valid       = 2'b00;
        intf.kill_valid     = 1'b0;
    endtask

    task automatic drv_disp(input int rob, input logic n0, input int t0,
                            input logic n1, input int t1, input bit push);
        ALU_RS_input_struct_t s;
        s = '0;
        s.op                    = 4'h3;
        s.ROB_index             = ROB_index_t'(rob);
        s.dest_tag              = phys_reg_tag_t'(rob + 32);
        s.imm16                 = 16'(rob * 3);
        s.source_0.needed       = n0;
        s.source_0.phys_reg_tag = phys_reg_tag_t'(t0);
        s.source_1.needed       = n1;
        s.source_1.phys_reg_tag = phys_reg_tag_t'(t1);
        intf.dispatch_struct    = s;
        intf.dispatch_valid     = 1'b1;
        if (push) sb.push_back(ROB_index_t'(rob));
    endtask

    task automatic do_reset();
        RST                 = 1'b1;
        intf.dispatch_valid = 1'b0;
        intf.dispatch_struct = '0;
        intf.wb_valid       = 2'b00;
        intf.wb_tag         = '0;
        intf.issue_ready    = 1'b0;
        intf.kill_valid     = 1'b0;
        intf.kill_ROB_index = '0;
        intf.ROB_head_index = '0;
        @(posedge CLK);
        #2;
        chk("rst_issue_valid", int'(intf.issue_valid), 0);
        chk("rst_dispatch_ready", int'(intf.dispatch_ready), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        sb.delete();
        #1;
        chk("post_rst_dispatch_ready", int'(intf.dispatch_ready), 1);
        chk("post_rst_issue_valid", int'(intf.issue_valid), 0);
        chk("post_rst_count", int'(dut.count_q), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit fired;

        kv[0] = '{head: 30, rob: '{30, 31, 0, 1},  kill: 31, exp_cnt: 2};
        kv[1] = '{head: 0,  rob: '{0, 1, 2, 3},    kill: 0,  exp_cnt: 1};
        kv[2] = '{head: 5,  rob: '{5, 6, 7, 8},    kill: 8,  exp_cnt: 4};
        kv[3] = '{head: 28, rob: '{29, 30, 31, 0}, kill: 30, exp_cnt: 2};
        kv[4] = '{head: 10, rob: '{12, 13, 14, 15}, kill: 12, exp_cnt: 1};

        // In-order issue of four independent instructions, one per cycle.
        do_reset();
        intf.ROB_head_index = 5'd3;
        intf.issue_ready    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv_disp(3 + k, 1'b0, 0, 1'b0, 0, 1'b1);
            #1;
            if (k > 0) chk("inorder_issue_valid", int'(intf.issue_valid), 1);
            adv();
        end
        #1 chk("inorder_last_valid", int'(intf.issue_valid), 1);
        adv();
        #1 chk("inorder_empty_after", int'(intf.issue_valid), 0);

        // Wakeup on bus 1 for tag 17; a non-matching broadcast must not wake it.
        do_reset();
        intf.issue_ready = 1'b1;
        drv_disp(10, 1'b1, 17, 1'b0, 0, 1'b1);
        adv();
        #1 chk("wait_tag17", int'(intf.issue_valid), 0);
        intf.wb_valid  = 2'b11;
        intf.wb_tag[0] = 6'd16;
        intf.wb_tag[1] = 6'd18;
        adv();
        #1 chk("no_false_wake", int'(intf.issue_valid), 0);
        intf.wb_valid  = 2'b10;
        intf.wb_tag[0] = 6'd0;
        intf.wb_tag[1] = 6'd17;
        #1;
`ifdef ALU_RS_BYPASS_WAKEUP_EN
        chk("wake_cycle_issue", int'(intf.issue_valid), 1);
`else
        chk("wake_cycle_issue", int'(intf.issue_valid), 0);
`endif
        adv();
`ifdef ALU_RS_BYPASS_WAKEUP_EN
        #1 chk("wake_next_issue", int'(intf.issue_valid), 0);
`else
        #1 chk("wake_next_issue", int'(intf.issue_valid), 1);
`endif
        adv();
        #1 chk("wake_drained", int'(intf.issue_valid), 0);

        // Full with nothing eligible; one fire reopens dispatch only on the following cycle.
        do_reset();
        intf.issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv_disp(k, 1'b1, 20 + k, 1'b0, 0, 1'b0);
            adv();
        end
        #1;
        chk("full_dispatch_ready", int'(intf.dispatch_ready), 0);
        chk("full_none_eligible", int'(intf.issue_valid), 0);
        chk("full_count", int'(dut.count_q), 4);
        intf.wb_valid  = 2'b01;
        intf.wb_tag[0] = 6'd22;
        sb.push_back(ROB_index_t'(2));
        fired = 1'b0;
        for (int c = 0; c < 4 && !fired; c++) begin
            #1;
            if (intf.issue_valid && intf.issue_ready) begin
                fired = 1'b1;
                chk("full_no_bypass", int'(intf.dispatch_ready), 0);
            end
            adv();
        end
        if (!fired) chk("full_fire_timeout", 0, 1);
        #1;
        chk("ready_after_fire", int'(intf.dispatch_ready), 1);
        chk("count_after_fire", int'(dut.count_q), 3);
        intf.wb_valid  = 2'b11;
        intf.wb_tag[0] = 6'd20;
        intf.wb_tag[1] = 6'd21;
        sb.push_back(ROB_index_t'(0));
        sb.push_back(ROB_index_t'(1));
        adv();
        intf.wb_valid  = 2'b01;
        intf.wb_tag[0] = 6'd23;
        sb.push_back(ROB_index_t'(3));
        adv();
        repeat (4) adv();
        #1 chk("full_drained_count", int'(dut.count_q), 0);

        // Wakeup in the dispatch cycle is captured into the stored entry.
        do_reset();
        intf.issue_ready = 1'b1;
        drv_disp(7, 1'b0, 0, 1'b1, 9, 1'b1);
        intf.wb_valid  = 2'b01;
        intf.wb_tag[0] = 6'd9;
        adv();
        #1;
        chk("disp_wake_issue", int'(intf.issue_valid), 1);
        chk("disp_wake_ready_bit", int'(intf.issue_struct.source_1.ready), 1);
        adv();
        #1 chk("disp_wake_drained", int'(intf.issue_valid), 0);

        // Reset mid-operation discards everything.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drv_disp(k, 1'b0, 0, 1'b0, 0, 1'b1);
            adv();
        end
        #1;
        chk("pre_rst_issue_valid", int'(intf.issue_valid), 1);
        chk("pre_rst_count", int'(dut.count_q), 3);
        RST = 1'b1;
        #1;
        chk("mid_rst_issue_valid", int'(intf.issue_valid), 0);
        chk("mid_rst_dispatch_ready", int'(intf.dispatch_ready), 0);
        adv();
        RST = 1'b0;
        sb.delete();
        #1;
        chk("after_rst_count", int'(dut.count_q), 0);
        chk("after_rst_issue_valid", int'(intf.issue_valid), 0);
        chk("after_rst_dispatch_ready", int'(intf.dispatch_ready), 1);

        // Kill and fire in the same cycle: the surviving oldest fires, the younger ones vanish.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drv_disp(k, 1'b0, 0, 1'b0, 0, 1'b1);
            adv();
        end
        intf.kill_valid     = 1'b1;
        intf.kill_ROB_index = 5'd0;
        intf.issue_ready    = 1'b1;
        void'(sb.pop_back());
        void'(sb.pop_back());
        #1 chk("kill_fire_valid", int'(intf.issue_valid), 1);
        adv();
        #1;
        chk("kill_fire_count", int'(dut.count_q), 0);
        chk("kill_fire_empty", int'(intf.issue_valid), 0);

        // A killed eligible entry is masked from selection in the kill cycle.
        do_reset();
        drv_disp(0, 1'b1, 40, 1'b0, 0, 1'b1);
        adv();
        drv_disp(1, 1'b0, 0, 1'b0, 0, 1'b0);
        adv();
        #1 chk("mask_pre_valid", int'(intf.issue_valid), 1);
        intf.kill_valid     = 1'b1;
        intf.kill_ROB_index = 5'd0;
        intf.issue_ready    = 1'b1;
        #1 chk("mask_kill_cycle", int'(intf.issue_valid), 0);
        adv();
        #1 chk("mask_count", int'(dut.count_q), 1);
        intf.wb_valid  = 2'b01;
        intf.wb_tag[0] = 6'd40;
        adv();
        repeat (2) adv();
        #1 chk("mask_drained", int'(dut.count_q), 0);

        // Kill-age table: wrap-around ages relative to the ROB head.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            intf.ROB_head_index = ROB_index_t'(kv[v].head);
            for (int k = 0; k < 4; k++) begin
                drv_disp(kv[v].rob[k], 1'b0, 0, 1'b0, 0, 1'b1);
                adv();
            end
            #1;
            chk("tbl_full_ready", int'(intf.dispatch_ready), 0);
            chk("tbl_full_count", int'(dut.count_q), 4);
            intf.kill_valid     = 1'b1;
            intf.kill_ROB_index = ROB_index_t'(kv[v].kill);
            for (int k = 0; k < 4 - kv[v].exp_cnt; k++) void'(sb.pop_back());
            #1 chk("tbl_kill_dispatch_ready", int'(intf.dispatch_ready), 0);
            adv();
            #1 chk("tbl_kill_count", int'(dut.count_q), kv[v].exp_cnt);
            intf.issue_ready = 1'b1;
            for (int c = 0; c < 12 && sb.size() > 0; c++) adv();
            #1;
            chk("tbl_drain_sb", sb.size(), 0);
            chk("tbl_drain_valid", int'(intf.issue_valid), 0);
            intf.issue_ready = 1'b0;
        end

        chk("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
